inv_mix_column_seq: RTL
=======================

// Module: inv_mix_column_seq
// PURPOSE
//  Sequential AES InvMixColumns engine for one 32-bit state column: multiplies each byte by
//  GF(2^8) coefficients 0E/0B/0D/09 (poly 0x11B) via xtime chains, ROWS_PER_CYCLE rows/clock.
//  Inverse-direction counterpart of the forward multiply_byte (x1/x2/x3) path; sits in the
//  decryption round datapath between InvShiftRows/InvSubBytes/AddRoundKey stages.
//  Valid/ready handshake on both sides; one column in flight.
// PARAMETERS
//  ROWS_PER_CYCLE  1  output rows computed per clock; legal 1,2,4 (latency = 4/ROWS_PER_CYCLE)
// PORTS
//  pi_clk          in   1   clock, rising edge
//  pi_rst_n        in   1   asynchronous active-low reset
//  pi_valid        in   1   input column valid
//  po_ready        out  1   engine can accept a column
//  pi_column       in   32  a0=[31:24] (row 0) .. a3=[7:0] (row 3)
//  po_valid        out  1   result column valid
//  pi_ready        in   1   downstream accepts result
//  po_column       out  32  b0=[31:24] .. b3=[7:0]
// BEHAVIOUR
//  - Math: b_i = 0E*a_i ^ 0B*a_(i+1) ^ 0D*a_(i+2) ^ 09*a_(i+3), indices mod 4.
//    xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); x2,x4,x8 by chaining;
//    09=x8^x, 0B=x8^x2^x, 0D=x8^x4^x, 0E=x8^x4^x2. All results 8-bit, no carries.
//  - FSM: IDLE -> CALC -> DONE -> IDLE.
//    IDLE: po_ready=1. On pi_valid&&po_ready: latch pi_column into a_r, clear b_r, row_cnt=0, ->CALC.
//    CALC: each clock compute rows row_cnt..row_cnt+ROWS_PER_CYCLE-1 from a_r into b_r;
//      row_cnt += ROWS_PER_CYCLE (2-bit, wraps); after last row group -> DONE, po_valid=1.
//    DONE: po_valid=1, po_column=b_r stable; on pi_ready -> IDLE (po_valid=0 next cycle).
//      pi_ready low: hold indefinitely, outputs unchanged.
//  - po_ready=0 in CALC and DONE; pi_valid there is ignored (not latched, no error).
//  - pi_column sampled only at accept edge; later input changes have no effect.
//  - Latency: accept edge at cycle T -> po_valid high after edge T+4/ROWS_PER_CYCLE
//    (ROWS_PER_CYCLE=1: 4 clocks; =4: 1 clock). Throughput: one column per latency+2 cycles min.
//  - No bypass: IDLE->accept and DONE->release never occur on the same edge.
//  - po_column in IDLE/CALC: holds last b_r (don't care for consumers; po_valid=0).
//  - Reset (any state, any time, async): state=IDLE, po_valid=0, po_ready=1 after reset release,
//    a_r=b_r=0, po_column=32'h0, row_cnt=0. Column in flight is discarded.
//  - Illegal ROWS_PER_CYCLE: elaboration-time error.
// TESTING
//  1. Accept 32'h8E4DA1BC, pi_ready=1 -> po_column=32'hDB135345, po_valid 4 clks after accept (RPC=1).
//  2. 32'h9FDC589D -> 32'hF20A225C; 32'h4D7EBDF8 -> 32'h2D26314C (x8 reduction path).
//  3. 32'h01010101 -> 32'h01010101; 32'hC6C6C6C6 -> 32'hC6C6C6C6; 32'hD5D5D7D6 -> 32'hD4D4D4D5.
//  4. Backpressure: pi_ready=0 for 10 clks in DONE -> po_valid/po_column stable, po_ready=0;
//     second column driven meanwhile is not accepted until after release + IDLE.
//  5. pi_rst_n low mid-CALC -> po_valid=0, po_column=0 immediately; next column computed correctly.
//  6. Repeat 1-3 with ROWS_PER_CYCLE=2 and 4 -> same results at latency 2 and 1; random
//     1000-column run vs. reference model (forward MixColumns of output == input).

Source files
------------

// File: rtl/inv_mix_column_seq_if.sv
// Column stream bundle: valid/ready handshake
// carrying one 32-bit AES state column.
interface inv_mix_column_seq_if;
  logic        valid;
  logic        ready;
  logic [31:0] column;

  modport master (
    output valid,
    output column,
    input  ready
  );

  modport slave (
    input  valid,
    input  column,
    output ready
  );
endinterface

// File: rtl/inv_mix_column_seq.sv
// Sequential AES InvMixColumns for one column,
// ROWS_PER_CYCLE output rows per clock.
module inv_mix_column_seq #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                  pi_clk,
  input  logic                  pi_rst_n,
  inv_mix_column_seq_if.slave   i_col,
  inv_mix_column_seq_if.master  o_col
);

  if (!(ROWS_PER_CYCLE == 1 ||
        ROWS_PER_CYCLE == 2 ||
        ROWS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [1:0] LAST =
    2'(4 - ROWS_PER_CYCLE);
  localparam logic [1:0] STEP =
    2'(ROWS_PER_CYCLE);

  state_t          r_state;
  state_t          w_next;
  logic [3:0][7:0] r_a;
  logic [3:0][7:0] r_b;
  logic [1:0]      r_row;
  logic            w_acc;
  logic            w_last;
  logic            w_rdy;
  logic            w_vld;
  logic [1:0]      w_idx [ROWS_PER_CYCLE];
  logic [7:0]      w_row [ROWS_PER_CYCLE];

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^
           (x[7] ? 8'h1B : 8'h00);
  endfunction

  // c selects which of x8/x4/x2/x1 to fold in
  function automatic logic [7:0] gm(
    input logic [7:0] x,
    input logic [3:0] c
  );
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[3] ? x8 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^
           (c[0] ? x  : 8'h00);
  endfunction

  // Row j lives in byte ~j (row 0 = [31:24])
  function automatic logic [7:0] inv_row(
    input logic [3:0][7:0] a,
    input logic [1:0]      j
  );
    logic [1:0] j1, j2, j3;
    j1 = j + 2'd1;
    j2 = j + 2'd2;
    j3 = j + 2'd3;
    return gm(a[~j],  4'hE) ^
           gm(a[~j1], 4'hB) ^
           gm(a[~j2], 4'hD) ^
           gm(a[~j3], 4'h9);
  endfunction

  for (genvar k = 0; k < ROWS_PER_CYCLE;
       k++) begin : g_row
    assign w_idx[k] = r_row + 2'(k);
    assign w_row[k] = inv_row(r_a, w_idx[k]);
  end

  assign w_acc  = (r_state == IDLE) &&
                  i_col.valid;
  assign w_last = (r_row == LAST);

  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b0;
    w_vld  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_rdy = 1'b1;
        if (i_col.valid) w_next = CALC;
      end
      CALC: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_vld = 1'b1;
        if (o_col.ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      r_a   <= i_col.column;
      r_b   <= '0;
      r_row <= '0;
    end else if (r_state == CALC) begin
      for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
        r_b[~w_idx[k]] <= w_row[k];
      end
      r_row <= r_row + STEP;
    end
  end

  assign i_col.ready  = w_rdy;
  assign o_col.valid  = w_vld;
  assign o_col.column = r_b;

endmodule
